// File: rtl/window_frame_sched.sv
// Frame scheduler for a 3x3 window generator feeding a credit-limited MAC.
// It sequences the frame, counts accepted windows, tracks credits and flags protocol errors.
module window_frame_sched #(
  parameter int unsigned WIDTH   = 480,
  parameter int unsigned HEIGHT  = 272,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CNT_W   = 18
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iAbort,
  output logic             oWinRstN,
  output logic             oWinEn,
  output logic             oWinBusy,
  input  logic             iWinValid,
  input  logic             iMacAck,
  output logic             oFrameBusy,
  output logic             oDone,
  output logic [CNT_W-1:0] oWinCount,
  output logic             oErr
);

  localparam int unsigned     CR_W      = $clog2(CREDITS + 1);
  localparam longint unsigned FRAME_PIX = longint'(WIDTH) * longint'(HEIGHT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);
  localparam logic [CR_W-1:0]  CR_FULL  = CR_W'(CREDITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Parameter sanity: counter must hold a full frame without wrapping.
  if (CREDITS < 1 || CREDITS > 15) begin : g_bad_credits
    $error("window_frame_sched: CREDITS must be in 1..15");
  end
  if (FRAME_PIX >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("window_frame_sched: WIDTH*HEIGHT does not fit in CNT_W bits");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CR_W-1:0]  cred_q,  cred_d;
  logic             err_q,   err_d;

  // State, counter, credit and error registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cred_q  <= CR_FULL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; an accepted start overrides credit/error updates of that cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cred_d  = cred_q;
    err_d   = err_q;

    if (iWinValid && !iMacAck) begin
      if (cred_q != '0) cred_d = cred_q - CR_W'(1);
    end else if (iMacAck && !iWinValid) begin
      if (cred_q != CR_FULL) cred_d = cred_q + CR_W'(1);
    end

    if (iWinValid && (cred_q == '0 || state_q != S_RUN)) err_d = 1'b1;
    if (iMacAck && !iWinValid && cred_q == CR_FULL)      err_d = 1'b1;

    if (iAbort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            state_d = S_RUN;
            cnt_d   = '0;
            err_d   = 1'b0;
            cred_d  = CR_FULL;
          end
        end
        S_RUN: begin
          if (iWinValid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cred_q == CR_FULL) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode registers only, so there is no path from iWinValid/iMacAck.
  assign oWinRstN   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign oWinEn     = (state_q == S_RUN);
  assign oWinBusy   = (state_q == S_RUN) && (cred_q == '0);
  assign oFrameBusy = (state_q != S_IDLE);
  assign oDone      = (state_q == S_DONE);
  assign oWinCount  = cnt_q;
  assign oErr       = err_q;

endmodule

// File: tb/tb_window_frame_sched.sv
// Self-checking bench for window_frame_sched (4x3 frame, 2 credits) against a behavioural model.
module tb_window_frame_sched;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 3;
  localparam int unsigned CR  = 2;
  localparam int unsigned CW  = 18;
  localparam int          PIX = W * H;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart, iAbort, iWinValid, iMacAck;
  logic          oWinRstN, oWinEn, oWinBusy, oFrameBusy, oDone, oErr;
  logic [CW-1:0] oWinCount;

  window_frame_sched #(.WIDTH(W), .HEIGHT(H), .CREDITS(CR), .CNT_W(CW)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort),
    .oWinRstN(oWinRstN), .oWinEn(oWinEn), .oWinBusy(oWinBusy),
    .iWinValid(iWinValid), .iMacAck(iMacAck), .oFrameBusy(oFrameBusy),
    .oDone(oDone), .oWinCount(oWinCount), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
  mstate_t m_state;
  int      m_cnt;
  int      m_cred;
  bit      m_err;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void model_reset();
    m_state = M_IDLE; m_cnt = 0; m_cred = CR; m_err = 0;
  endfunction

  // One clock of the frame rules, evaluated from the pre-edge model state.
  function automatic void model_step(input bit st, input bit ab, input bit v, input bit a);
    mstate_t s = m_state;
    int c = m_cred;
    if (s == M_IDLE && st) begin
      m_state = M_RUN; m_cnt = 0; m_err = 0; m_cred = CR;
      return;
    end
    if (v && (c == 0 || s != M_RUN)) m_err = 1;
    if (a && !v && c == CR) m_err = 1;
    if (v && !a) m_cred = (c > 0) ? c - 1 : 0;
    if (a && !v) m_cred = (c < CR) ? c + 1 : CR;
    if (ab && s != M_IDLE) begin
      m_state = M_IDLE;
      return;
    end
    case (s)
      M_RUN:   if (v) begin
                 if (m_cnt == PIX - 1) m_state = M_DRAIN;
                 m_cnt++;
               end
      M_DRAIN: if (c == CR) m_state = M_DONE;
      M_DONE:  m_state = M_IDLE;
      default: ;
    endcase
  endfunction

  function automatic logic [5:0] exp_flags();
    return {(m_state == M_RUN || m_state == M_DRAIN), (m_state == M_RUN),
            (m_state == M_RUN && m_cred == 0), (m_state != M_IDLE),
            (m_state == M_DONE), m_err};
  endfunction

  function automatic logic [5:0] obs_flags();
    return {oWinRstN, oWinEn, oWinBusy, oFrameBusy, oDone, oErr};
  endfunction

  task automatic tick(input logic st, input logic ab, input logic v, input logic a);
    iStart = st; iAbort = ab; iWinValid = v; iMacAck = a;
    @(posedge iClk);
    model_step(st, ab, v, a);
    #1;
    iStart = 0; iAbort = 0; iWinValid = 0; iMacAck = 0;
  endtask

  task automatic test_reset();
    iRst = 1; iStart = 0; iAbort = 0; iWinValid = 0; iMacAck = 0;
    model_reset();
    repeat (2) @(posedge iClk);
    #1;
    n_chk++;
    if (obs_flags() !== 6'b000000 || oWinCount !== '0) begin
      $display("FAIL reset_hold: flags=%b cnt=%0d, required flags=000000 cnt=0", obs_flags(), oWinCount);
    end else n_pass++;
    iRst = 0;
    #1;
  endtask

  task automatic test_nominal();
    int dones = 0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < PIX; i++) begin
      tick(0, 0, 1, 0);
      if (oDone) dones++;
      tick(0, 0, 0, 1);
      if (oDone) dones++;
      n_chk++;
      if (obs_flags() !== exp_flags() || oWinCount !== CW'(m_cnt)) begin
        $display("FAIL nominal_step%0d: flags=%b cnt=%0d, required flags=%b cnt=%0d",
                 i, obs_flags(), oWinCount, exp_flags(), m_cnt);
      end else n_pass++;
    end
    for (int i = 0; i < 6 && oFrameBusy; i++) begin
      tick(0, 0, 0, 0);
      if (oDone) dones++;
    end
    n_chk++;
    if (oWinCount !== CW'(PIX) || dones != 1 || oErr !== 1'b0 || oFrameBusy !== 1'b0) begin
      $display("FAIL nominal_end: cnt=%0d dones=%0d err=%b busy=%b, required cnt=%0d dones=1 err=0 busy=0",
               oWinCount, dones, oErr, oFrameBusy, PIX);
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    n_chk++;
    if (oWinBusy !== 1'b0) $display("FAIL bp_one_valid: busy=%b, required 0", oWinBusy);
    else n_pass++;
    tick(0, 0, 1, 0);
    n_chk++;
    if (oWinBusy !== 1'b1) $display("FAIL bp_two_valid: busy=%b, required 1", oWinBusy);
    else n_pass++;
    tick(0, 0, 0, 1);
    n_chk++;
    if (oWinBusy !== 1'b0) $display("FAIL bp_ack_release: busy=%b, required 0", oWinBusy);
    else n_pass++;
    tick(0, 1, 0, 0);
  endtask

  task automatic test_simultaneous();
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    n_chk++;
    if (oWinBusy !== 1'b0 || m_cred != 1) $display("FAIL simul_busy: busy=%b, required 0 (credit 1)", oWinBusy);
    else n_pass++;
    tick(0, 0, 1, 0);
    n_chk++;
    if (oWinBusy !== 1'b1) $display("FAIL simul_credit_kept: busy=%b, required 1", oWinBusy);
    else n_pass++;
    tick(0, 1, 0, 0);
  endtask

  task automatic test_errors();
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    n_chk++;
    if (oErr !== 1'b1 || oWinBusy !== 1'b1 || oWinCount !== CW'(3)) begin
      $display("FAIL err_valid_at_zero: err=%b busy=%b cnt=%0d, required err=1 busy=1 cnt=3", oErr, oWinBusy, oWinCount);
    end else n_pass++;
    tick(0, 0, 0, 1);
    n_chk++;
    if (oWinBusy !== 1'b0) $display("FAIL err_credit_saturated_low: busy=%b, required 0", oWinBusy);
    else n_pass++;
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    n_chk++;
    if (oErr !== 1'b0) $display("FAIL err_cleared_by_start: err=%b, required 0", oErr);
    else n_pass++;
    tick(0, 0, 0, 1);
    n_chk++;
    if (oErr !== 1'b1) $display("FAIL err_spurious_ack: err=%b, required 1", oErr);
    else n_pass++;
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    n_chk++;
    if (oWinBusy !== 1'b1) $display("FAIL err_credit_saturated_high: busy=%b, required 1", oWinBusy);
    else n_pass++;
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    n_chk++;
    if (oWinCount !== CW'(2) || oErr !== 1'b1) begin
      $display("FAIL err_valid_in_idle: cnt=%0d err=%b, required cnt=2 err=1", oWinCount, oErr);
    end else n_pass++;
    tick(1, 0, 0, 0);
    n_chk++;
    if (oErr !== 1'b0) $display("FAIL err_cleared_again: err=%b, required 0", oErr);
    else n_pass++;
    tick(0, 1, 0, 0);
  endtask

  task automatic test_abort();
    int dones = 0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 1);
    end
    tick(0, 1, 0, 0);
    n_chk++;
    if (oFrameBusy !== 1'b0 || oWinRstN !== 1'b0 || oWinEn !== 1'b0 || oWinCount !== CW'(5)) begin
      $display("FAIL abort_idle: busy=%b rstn=%b en=%b cnt=%0d, required 0 0 0 5",
               oFrameBusy, oWinRstN, oWinEn, oWinCount);
    end else n_pass++;
    repeat (4) begin
      tick(0, 0, 0, 0);
      if (oDone) dones++;
    end
    n_chk++;
    if (dones != 0) $display("FAIL abort_no_done: pulses=%0d, required 0", dones);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 1);
    end
    tick(1, 0, 0, 0);
    n_chk++;
    if (oWinCount !== CW'(3) || oWinEn !== 1'b1) begin
      $display("FAIL start_in_run: cnt=%0d en=%b, required cnt=3 en=1", oWinCount, oWinEn);
    end else n_pass++;
    tick(0, 1, 0, 0);
  endtask

  task automatic test_reset_mid_drain();
    tick(1, 0, 0, 0);
    for (int i = 0; i < PIX - 1; i++) begin
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 1);
    end
    tick(0, 0, 1, 0);
    n_chk++;
    if (oWinRstN !== 1'b1 || oWinEn !== 1'b0 || oFrameBusy !== 1'b1) begin
      $display("FAIL drain_entered: rstn=%b en=%b busy=%b, required 1 0 1", oWinRstN, oWinEn, oFrameBusy);
    end else n_pass++;
    iRst = 1;
    #1;
    model_reset();
    n_chk++;
    if (obs_flags() !== 6'b000000 || oWinCount !== '0) begin
      $display("FAIL reset_mid_drain: flags=%b cnt=%0d, required flags=000000 cnt=0", obs_flags(), oWinCount);
    end else n_pass++;
    @(posedge iClk);
    #1;
    iRst = 0;
    tick(1, 0, 0, 0);
    n_chk++;
    if (oFrameBusy !== 1'b1 || oWinEn !== 1'b1) begin
      $display("FAIL start_after_reset: busy=%b en=%b, required 1 1", oFrameBusy, oWinEn);
    end else n_pass++;
    tick(0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      n_chk++;
      if (obs_flags() !== exp_flags() || oWinCount !== CW'(m_cnt)) begin
        $display("FAIL random_cyc%0d: flags=%b cnt=%0d, required flags=%b cnt=%0d",
                 i, obs_flags(), oWinCount, exp_flags(), m_cnt);
      end else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_simultaneous();
    test_errors();
    test_abort();
    test_start_ignored();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/window_frame_sched.md
WINDOW_FRAME_SCHED -- requirements
Module: window_frame_sched

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default, meaning:
- WIDTH, 480, frame width in pixels
- HEIGHT, 272, frame height in pixels
- CREDITS, 4, window slots in the downstream MAC input buffer (1..15)
- CNT_W, 18, window-counter width
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- iClk, input, 1, single clock; all state changes on its rising edge
- iRst, input, 1, reset; asynchronous, active-high
- iStart, input, 1, frame start request
- iAbort, input, 1, abort the current frame
- oWinRstN, output, 1, active-low reset to the 3x3 window generator
- oWinEn, output, 1, enable to the window generator
- oWinBusy, output, 1, stall to the window generator
- iWinValid, input, 1, window generator output valid, already qualified by !busy
- iMacAck, input, 1, MAC consumed one window and returns one credit
- oFrameBusy, output, 1, frame in progress
- oDone, output, 1, frame complete pulse
- oWinCount, output, CNT_W, windows accepted in the current frame
- oErr, output, 1, sticky protocol error flag

Function
REQ-003 The state machine SHALL have four states, IDLE, RUN, DRAIN and DONE, held in a register.
REQ-004 In IDLE, iStart=1 SHALL move the block to RUN on the next edge, clear oWinCount to 0, clear oErr, and reload the credit counter to CREDITS.
REQ-005 iStart SHALL be ignored in every state other than IDLE.
REQ-006 In RUN, each cycle with iWinValid=1 SHALL increment oWinCount by 1.
REQ-007 In RUN, iWinValid=1 while oWinCount = WIDTH*HEIGHT-1 SHALL move the block to DRAIN.
REQ-008 In DRAIN, the block SHALL move to DONE on the first cycle in which the credit counter equals CREDITS.
REQ-009 DONE SHALL last exactly one cycle and SHALL then return to IDLE.
REQ-010 oDone SHALL equal 1 only while in DONE.
REQ-011 iAbort=1 in RUN, DRAIN or DONE SHALL force IDLE on the next edge. No oDone pulse SHALL follow, and oWinCount SHALL hold its value. iAbort has priority over every other transition.
REQ-012 oWinRstN SHALL be 0 in IDLE and DONE and 1 in RUN and DRAIN, so the window generator restarts from its initial state each frame.
REQ-013 oWinEn SHALL be 1 only in RUN.
REQ-014 oFrameBusy SHALL be 1 in RUN, DRAIN and DONE.
REQ-015 The credit counter SHALL be $clog2(CREDITS+1) bits wide and update every cycle:
- -1 on iWinValid only
- +1 on iMacAck only
- unchanged when both or neither are asserted
REQ-016 oWinBusy SHALL equal (state==RUN && credit==0), decoded only from registers. It SHALL have no combinational path from iWinValid or iMacAck, which avoids a loop through the generator's valid gating.
REQ-017 A credit that reaches 0 in cycle N SHALL assert oWinBusy in cycle N+1; one-cycle latency, no lookahead.
REQ-018 iWinValid=1 with credit=0 SHALL set oErr. The window SHALL still be counted and the credit SHALL saturate at 0.
REQ-019 iMacAck=1 with credit=CREDITS and no simultaneous iWinValid SHALL set oErr, and the credit SHALL saturate at CREDITS.
REQ-020 iWinValid outside RUN SHALL set oErr and SHALL NOT change oWinCount.
REQ-021 oErr SHALL be cleared only by reset or by an accepted iStart.
REQ-022 oWinCount SHALL never wrap within a frame. WIDTH*HEIGHT SHALL be less than 2^CNT_W; an elaboration check fails otherwise.

Reset
REQ-023 While iRst=1, the block SHALL hold: state=IDLE, oWinRstN=0, oWinEn=0, oWinBusy=0, oFrameBusy=0, oDone=0, oWinCount=0, oErr=0, credit=CREDITS.
REQ-024 An iRst assertion mid-frame SHALL take effect without a clock edge and discard the frame without an oDone pulse.
REQ-025 After iRst deasserts, the first iStart SHALL be honoured on the next edge.

Verification (WIDTH=4, HEIGHT=3, CREDITS=2)
REQ-026 Nominal frame: iStart, then 12 valids each followed by an ack in the next cycle -> oWinCount=12, DRAIN then DONE, exactly one oDone pulse, oErr=0.
REQ-027 Backpressure: 2 valids with no acks -> oWinBusy=1 on the cycle after the second valid; one ack -> oWinBusy=0 next cycle.
REQ-028 Simultaneous events: valid and ack in the same cycle at credit=1 -> credit stays 1 and oWinBusy stays 0.
REQ-029 Protocol errors: forced valid at credit=0 -> oErr=1 and credit remains 0; spurious ack at full credit -> oErr=1; next iStart -> oErr=0.
REQ-030 Abort and reset: iAbort after 5 windows -> IDLE next cycle, oWinCount=5, no oDone, oWinRstN=0. iRst mid-DRAIN -> all outputs at reset values immediately. iStart ignored during RUN -> oWinCount unaffected.
